// File: rtl/oled_spi_receiver.sv
// Loopback receiver for the OLED serial link: rebuilds bytes from SCLK/SDIN,
// tracks the SSD1306 command subset and mirrors data bytes into a shadow frame buffer.
module oled_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS        = 128,
  parameter int PAGES       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             oledSCLK,
  input  logic                             oledSDIN,
  input  logic                             oledDC,
  input  logic                             oledRES,
  input  logic [$clog2(PAGES*COLS)-1:0]    rdAddr,
  output logic [7:0]                       rdData,
  output logic                             byteValid,
  output logic [7:0]                       byteData,
  output logic                             byteIsData,
  output logic                             displayOn,
  output logic                             frameDone,
  output logic [15:0]                      frameCount,
  output logic                             protoErr
);

  localparam int ADDR_W = $clog2(PAGES*COLS);
  localparam int COL_W  = $clog2(COLS);
  localparam int PAGE_W = $clog2(PAGES);

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} cmdState_t;

  logic [SYNC_STAGES-1:0] sclkSync, sdinSync, dcSync, resSync;
  logic                   sclkS, sdinS, dcS, resS;
  logic                   sclkPrev, riseReg, sdinReg, dcReg;

  logic [2:0]             bitCnt;
  logic [7:0]             shiftReg;
  logic [7:0]             newByte;
  logic                   byteDone;
  logic                   wrEn;
  logic [ADDR_W-1:0]      wrAddr;

  cmdState_t              cmdState;
  logic [7:0]             cmdReg;
  logic [7:0]             argReg;
  logic [COL_W-1:0]       colPtr, colStart, colEnd;
  logic [PAGE_W-1:0]      pagePtr, pageStart, pageEnd;
  logic                   colArgsOk, pageArgsOk;

  logic [7:0]             fb [PAGES*COLS];

  assign sclkS = sclkSync[SYNC_STAGES-1];
  assign sdinS = sdinSync[SYNC_STAGES-1];
  assign dcS   = dcSync[SYNC_STAGES-1];
  assign resS  = resSync[SYNC_STAGES-1];

  // RES chain resets to the inactive level so rst alone never looks like a display reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclkSync <= '0;
      sdinSync <= '0;
      dcSync   <= '0;
      resSync  <= '1;
      sclkPrev <= 1'b0;
      riseReg  <= 1'b0;
      sdinReg  <= 1'b0;
      dcReg    <= 1'b0;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], oledSCLK};
      sdinSync <= {sdinSync[SYNC_STAGES-2:0], oledSDIN};
      dcSync   <= {dcSync[SYNC_STAGES-2:0], oledDC};
      resSync  <= {resSync[SYNC_STAGES-2:0], oledRES};
      sclkPrev <= sclkS;
      riseReg  <= sclkS & ~sclkPrev;
      sdinReg  <= sdinS;
      dcReg    <= dcS;
    end
  end

  assign newByte  = {shiftReg[6:0], sdinReg};
  assign byteDone = riseReg & resS & (bitCnt == 3'd7);
  assign wrEn     = byteDone & dcReg;
  assign wrAddr   = {pagePtr, colPtr};

  assign colArgsOk  = (int'(argReg) < COLS) && (int'(newByte) < COLS) && (argReg <= newByte);
  assign pageArgsOk = (int'(argReg) < PAGES) && (int'(newByte) < PAGES) && (argReg <= newByte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt     <= '0;
      shiftReg   <= '0;
      cmdState   <= IDLE;
      cmdReg     <= '0;
      argReg     <= '0;
      colPtr     <= '0;
      colStart   <= '0;
      colEnd     <= COL_W'(COLS - 1);
      pagePtr    <= '0;
      pageStart  <= '0;
      pageEnd    <= PAGE_W'(PAGES - 1);
      byteValid  <= 1'b0;
      byteData   <= '0;
      byteIsData <= 1'b0;
      displayOn  <= 1'b0;
      frameDone  <= 1'b0;
      frameCount <= '0;
      protoErr   <= 1'b0;
    end else begin
      byteValid <= 1'b0;
      frameDone <= 1'b0;
      if (frameDone) frameCount <= frameCount + 16'd1;

      if (!resS) begin
        bitCnt    <= '0;
        shiftReg  <= '0;
        cmdState  <= IDLE;
        cmdReg    <= '0;
        argReg    <= '0;
        colPtr    <= '0;
        colStart  <= '0;
        colEnd    <= COL_W'(COLS - 1);
        pagePtr   <= '0;
        pageStart <= '0;
        pageEnd   <= PAGE_W'(PAGES - 1);
        displayOn <= 1'b0;
      end else if (riseReg) begin
        shiftReg <= newByte;
        bitCnt   <= bitCnt + 3'd1;
        if (bitCnt == 3'd7) begin
          byteValid  <= 1'b1;
          byteData   <= newByte;
          byteIsData <= dcReg;
          if (dcReg) begin
            // A data byte in the middle of a command abandons that command
            if (cmdState != IDLE) begin
              protoErr <= 1'b1;
              cmdState <= IDLE;
            end
            if (colPtr == colEnd) begin
              colPtr <= colStart;
              if (pagePtr == pageEnd) begin
                pagePtr   <= pageStart;
                frameDone <= 1'b1;
              end else begin
                pagePtr <= pagePtr + PAGE_W'(1);
              end
            end else begin
              colPtr <= colPtr + COL_W'(1);
            end
          end else begin
            unique case (cmdState)
              IDLE: begin
                unique case (newByte)
                  8'hAE: displayOn <= 1'b0;
                  8'hAF: displayOn <= 1'b1;
                  8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                  8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                    cmdReg   <= newByte;
                    cmdState <= ARG1;
                  end
                  default: ;
                endcase
              end
              ARG1: begin
                if (cmdReg == 8'h21 || cmdReg == 8'h22) begin
                  argReg   <= newByte;
                  cmdState <= ARG2;
                end else begin
                  if (cmdReg == 8'h20 && newByte != 8'h00) protoErr <= 1'b1;
                  cmdState <= IDLE;
                end
              end
              ARG2: begin
                if (cmdReg == 8'h21) begin
                  if (colArgsOk) begin
                    colStart <= COL_W'(argReg);
                    colEnd   <= COL_W'(newByte);
                    colPtr   <= COL_W'(argReg);
                  end else begin
                    protoErr <= 1'b1;
                  end
                end else begin
                  if (pageArgsOk) begin
                    pageStart <= PAGE_W'(argReg);
                    pageEnd   <= PAGE_W'(newByte);
                    pagePtr   <= PAGE_W'(argReg);
                  end else begin
                    protoErr <= 1'b1;
                  end
                end
                cmdState <= IDLE;
              end
              default: cmdState <= IDLE;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) fb[wrAddr] <= newByte;
  end

  // Read-first: a same-cycle write is seen on the following read only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdData <= '0;
    else     rdData <= fb[rdAddr];
  end

endmodule
